// File: rtl/trace_pkg.sv
// Shared entry type and field widths for the commit trace buffer.
// Defining TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp (ts) to every entry.
package trace_pkg;

  localparam int REG_NUM_W = 32'd5;
  localparam int ADDR_W    = 32'd9;
  localparam int TDATA_W   = 32'd32;
  localparam int TS_W      = 32'd32;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]      ts;
`endif
    logic                 rw;
    logic                 ms;
    logic                 ml;
    logic [REG_NUM_W-1:0] reg_num;
    logic [ADDR_W-1:0]    addr;
    logic [TDATA_W-1:0]   reg_data;
    logic [TDATA_W-1:0]   mem_data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular-buffer FIFO with occupancy counter; a push into a full FIFO is
// only taken when the head is popped on the same edge, otherwise it is dropped.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  T                       i_data,
  output T                       o_data,
  output logic                   o_valid,
  output logic                   o_drop,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  // Push/pop qualification; pops on an empty FIFO are ignored.
  always_comb begin
    w_full = (r_level == (PTR_W+1)'(DEPTH));
    w_pop  = i_pop & (r_level != '0);
    w_push = i_push & (~w_full | w_pop);
    o_drop = i_push & w_full & ~w_pop;
  end

  // Storage is deliberately left without reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push && reset) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Head presentation; an empty FIFO shows an all-zero entry.
  always_comb begin
    o_valid = (r_level != '0);
    o_level = r_level;
    if (o_valid) begin
      o_data = r_mem[r_rd_ptr];
    end else begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures core writeback and data-memory events into a trace FIFO with loss
// accounting. Optional macro TRACE_TIMESTAMP_EN stamps entries with a cycle count.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [8:0]             addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output trace_entry_t           trace_entry,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic [$clog2(DEPTH):0] level
);

  logic         w_rw;
  logic         w_event;
  logic         w_drop;
  trace_entry_t w_entry;
  logic         r_overflow;
  logic [15:0]  r_drop_count;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_cycle;

  // Free-running cycle stamp, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end
`endif

  // Event classification and entry formatting; unused fields are zeroed.
  always_comb begin
    w_rw             = reg_write_sig & (reg_num != 5'd0);
    w_event          = trace_en & (w_rw | wr | rd);
    w_entry          = '0;
    w_entry.rw       = w_rw;
    w_entry.ms       = wr;
    w_entry.ml       = rd;
    if (w_rw) begin
      w_entry.reg_num  = reg_num;
      w_entry.reg_data = TDATA_W'(reg_data);
    end else begin
      w_entry.reg_num  = 5'd0;
      w_entry.reg_data = '0;
    end
    if (wr | rd) begin
      w_entry.addr = addr;
    end else begin
      w_entry.addr = 9'd0;
    end
    // A simultaneous store and load reports the store data.
    if (wr) begin
      w_entry.mem_data = TDATA_W'(wr_data);
    end else if (rd) begin
      w_entry.mem_data = TDATA_W'(rd_data);
    end else begin
      w_entry.mem_data = '0;
    end
`ifdef TRACE_TIMESTAMP_EN
    w_entry.ts = r_cycle;
`endif
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_event),
    .i_pop   (trace_ready),
    .i_data  (w_entry),
    .o_data  (trace_entry),
    .o_valid (trace_valid),
    .o_drop  (w_drop),
    .o_level (level)
  );

  // Sticky loss flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end else begin
        r_drop_count <= r_drop_count;
      end
    end else begin
      r_overflow   <= r_overflow;
      r_drop_count <= r_drop_count;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomised self-checking bench for commit_trace_buffer against a queue model.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              trace_en = 1'b0;
  logic              reg_write_sig = 1'b0;
  logic [4:0]        reg_num = 5'd0;
  logic [DATA_W-1:0] reg_data = '0;
  logic              wr = 1'b0;
  logic              rd = 1'b0;
  logic [8:0]        addr = 9'd0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  trace_entry_t      trace_entry;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [LVL_W-1:0]  level;

  commit_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_entry(trace_entry),
    .overflow(overflow), .drop_count(drop_count), .level(level)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  trace_entry_t m_q[$];
  bit           m_ovf;
  int           m_drops;
  logic [31:0]  m_ts;

  // Entry the current inputs should produce, from the capture rules.
  function automatic trace_entry_t exp_entry();
    trace_entry_t e;
    bit is_rw;
    e = '0;
    is_rw = reg_write_sig && (reg_num != 5'd0);
    e.rw = is_rw;
    e.ms = wr;
    e.ml = rd;
    if (is_rw) begin
      e.reg_num  = reg_num;
      e.reg_data = reg_data;
    end
    if (wr || rd) e.addr = addr;
    if (wr) e.mem_data = wr_data;
    else if (rd) e.mem_data = rd_data;
`ifdef TRACE_TIMESTAMP_EN
    e.ts = m_ts;
`endif
    return e;
  endfunction

  function automatic void model_update();
    int pre;
    bit pop, ev;
    if (!reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_drops = 0;
      m_ts = 32'd0;
      return;
    end
    pre = m_q.size();
    pop = trace_ready && (pre > 0);
    ev  = trace_en && ((reg_write_sig && reg_num != 5'd0) || wr || rd);
    if (ev) begin
      if (pre < DEPTH || pop) m_q.push_back(exp_entry());
      else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (pop) void'(m_q.pop_front());
    m_ts = m_ts + 32'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    trace_en = 1'b1; reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = '0; rd_data = '0;
  endtask

  task automatic rand_event();
    reg_write_sig = 1'b1;
    reg_num  = 5'($urandom_range(1, 31));
    reg_data = $urandom;
    wr = ($urandom_range(0, 3) == 0);
    rd = ($urandom_range(0, 3) == 0);
    addr = 9'($urandom);
    wr_data = $urandom;
    rd_data = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b0; idle(); trace_ready = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_tests++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
    n_tests++; if (trace_entry !== trace_entry_t'(0)) begin n_fail++; $display("FAIL reset_entry: got %h want 0", trace_entry); end
  endtask

  task automatic test_reg_write();
    idle(); reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'h1234;
    step(); idle();
    n_tests++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL regw_valid: got %b want 1", trace_valid); end
    n_tests++; if ({trace_entry.rw, trace_entry.ms, trace_entry.ml} !== 3'b100) begin n_fail++; $display("FAIL regw_flags: got %b want 100", {trace_entry.rw, trace_entry.ms, trace_entry.ml}); end
    n_tests++; if (trace_entry.reg_num !== 5'd5 || trace_entry.reg_data !== 32'h1234) begin n_fail++; $display("FAIL regw_fields: got %0d/%h want 5/1234", trace_entry.reg_num, trace_entry.reg_data); end
    n_tests++; if (m_q.size() != 1 || trace_entry !== m_q[0]) begin n_fail++; $display("FAIL regw_entry: got %h", trace_entry); end
    trace_ready = 1'b1; step(); trace_ready = 1'b0;
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL regw_drain: got %0d want 0", level); end
  endtask

  task automatic test_reg_zero();
    idle(); reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = $urandom;
    step(); idle(); step();
    n_tests++; if (level !== 5'd0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL r0_nopush: got level %0d valid %b want 0/0", level, trace_valid); end
  endtask

  task automatic test_load();
    idle(); rd = 1'b1; addr = 9'h010; rd_data = 32'hCAFE;
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = $urandom;
    step(); idle();
    n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL load_level: got %0d want 1", level); end
    n_tests++; if ({trace_entry.rw, trace_entry.ms, trace_entry.ml} !== 3'b101) begin n_fail++; $display("FAIL load_flags: got %b want 101", {trace_entry.rw, trace_entry.ms, trace_entry.ml}); end
    n_tests++; if (trace_entry.mem_data !== 32'hCAFE || trace_entry.addr !== 9'h010 || trace_entry.reg_num !== 5'd7) begin n_fail++; $display("FAIL load_fields: got %h/%h/%0d", trace_entry.mem_data, trace_entry.addr, trace_entry.reg_num); end
    trace_ready = 1'b1; step(); trace_ready = 1'b0;
  endtask

  task automatic test_overflow();
    trace_entry_t held;
    idle(); trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin rand_event(); step(); end
    idle();
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", level); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_tests++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drops: got %0d want 2", drop_count); end
    held = trace_entry;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (trace_entry !== held || trace_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_stall: got %h want %h", trace_entry, held); end
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (m_q.size() == 0 || trace_entry !== m_q[0]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h", i, trace_entry); end
      step();
    end
    trace_ready = 1'b0;
    n_tests++; if (level !== 5'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got level %0d ovf %b want 0/1", level, overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] drops_before;
    idle(); trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin rand_event(); step(); end
    drops_before = drop_count;
    rand_event(); trace_ready = 1'b1;
    step(); idle(); trace_ready = 1'b0;
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL fullpp_level: got %0d want 16", level); end
    n_tests++; if (drop_count !== drops_before) begin n_fail++; $display("FAIL fullpp_drops: got %0d want %0d", drop_count, drops_before); end
    n_tests++; if (trace_entry !== m_q[0]) begin n_fail++; $display("FAIL fullpp_head: got %h want %h", trace_entry, m_q[0]); end
  endtask

  task automatic test_trace_en_off();
    trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_event(); trace_en = 1'b0;
      step();
      n_tests++; if (level !== LVL_W'(m_q.size())) begin n_fail++; $display("FAIL en_off_level[%0d]: got %0d want %0d", i, level, m_q.size()); end
    end
    idle(); trace_ready = 1'b0;
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL en_off_empty: got %0d want 0", level); end
  endtask

  task automatic test_mid_reset();
    idle(); trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_event(); step(); end
    n_tests++; if (level !== 5'd5) begin n_fail++; $display("FAIL midrst_fill: got %0d want 5", level); end
    rand_event(); trace_ready = 1'b1; reset = 1'b0;
    step(); reset = 1'b1; idle(); trace_ready = 1'b0;
    n_tests++; if (level !== 5'd0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_empty: got level %0d valid %b want 0/0", level, trace_valid); end
    n_tests++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin n_fail++; $display("FAIL midrst_loss: got ovf %b drops %0d want 0/0", overflow, drop_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      trace_en = ($urandom_range(0, 9) != 0);
      reg_write_sig = $urandom_range(0, 1);
      reg_num = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      reg_data = $urandom;
      wr = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 3) == 0);
      addr = 9'($urandom); wr_data = $urandom; rd_data = $urandom;
      trace_ready = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 8));
      step();
      n_tests++; if (level !== LVL_W'(m_q.size()) || trace_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d/%b want %0d", i, level, trace_valid, m_q.size()); end
      n_tests++; if (overflow !== m_ovf || drop_count !== 16'(m_drops)) begin n_fail++; $display("FAIL rnd_loss[%0d]: got %b/%0d want %b/%0d", i, overflow, drop_count, m_ovf, m_drops); end
      if (m_q.size() != 0) begin
        n_tests++; if (trace_entry !== m_q[0]) begin n_fail++; $display("FAIL rnd_entry[%0d]: got %h want %h", i, trace_entry, m_q[0]); end
      end
    end
    idle(); trace_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_reg_zero();
    test_load();
    test_overflow();
    test_full_push_pop();
    test_trace_en_off();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data bus width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-low reset (0 = reset).
REQ-005 SHALL have port trace_en, input, 1, meaning capture enable.
REQ-006 SHALL have ports reg_write_sig/reg_num/reg_data, input, 1/5/DATA_W, meaning the core's writeback event.
REQ-007 SHALL have ports wr/rd/addr/wr_data/rd_data, input, 1/1/9/DATA_W/DATA_W, meaning the core's data-memory access.
REQ-008 SHALL have port trace_valid, output, 1, meaning the head entry is available.
REQ-009 SHALL have port trace_ready, input, 1, meaning the consumer accepts the head entry.
REQ-010 SHALL have port trace_entry, output, trace_entry_t width, meaning the head entry.
REQ-011 SHALL have ports overflow/drop_count, output, 1/16, meaning sticky loss flag and saturating dropped-event count.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1, meaning current occupancy.

Function
REQ-013 SHALL classify an event per cycle: rw = reg_write_sig & (reg_num != 0); ms = wr; ml = rd.
REQ-014 SHALL push exactly one entry in a cycle with trace_en=1 and (rw|ms|ml); the entry is {rw,ms,ml, reg_num, addr, reg_data, mem_data}.
REQ-015 SHALL set mem_data = wr_data when ms=1, rd_data when ml=1, 0 otherwise; if wr and rd are both 1, ms=ml=1 and mem_data=wr_data.
REQ-016 SHALL zero the reg_num and reg_data fields when rw=0, and the addr field when ms=ml=0.
REQ-017 SHALL make a pushed entry visible on trace_entry with trace_valid=1 the cycle after the push edge (1-cycle latency).
REQ-018 SHALL pop the head on an edge where trace_valid & trace_ready.
REQ-019 SHALL drive trace_valid = (level != 0) and SHALL keep trace_entry stable while trace_valid=1 and trace_ready=0.
REQ-020 SHALL accept a push when full only if a pop occurs on the same edge; level is then unchanged.
REQ-021 SHALL drop a push when full without a same-cycle pop, set overflow=1 (sticky until reset), and increment drop_count, saturating at 16'hFFFF.
REQ-022 SHALL wrap read and write pointers modulo DEPTH without loss.
REQ-023 SHALL make level count up on push-only, down on pop-only, and stay unchanged on push+pop.
REQ-024 SHALL ignore trace_ready when empty.
REQ-025 SHALL, when trace_en=0, push nothing while draining continues normally.

Reset
REQ-026 SHALL, on an edge with reset=0, set pointers and level to 0, trace_valid=0, overflow=0 and drop_count=0, and drive trace_entry to all-zero.
REQ-027 SHALL discard all contents on a mid-operation reset, with no push or pop on that edge.
REQ-028 SHALL leave FIFO storage RAM uninitialised on reset.

Configuration
REQ-029 SHALL, with macro TRACE_TIMESTAMP_EN defined, add a free-running 32-bit cycle counter (reset to 0, wrapping) and a ts field captured at push time into trace_entry_t.
REQ-030 SHALL, without TRACE_TIMESTAMP_EN, omit the counter and the ts field; trace_entry_t has no ts member.

Structure
REQ-031 SHALL place trace_entry_t (packed struct) and the field-width constants in package trace_pkg, with ts guarded by TRACE_TIMESTAMP_EN.
REQ-032 SHALL implement storage and pointer logic in one sub-module, trace_fifo, parameterised by DEPTH and entry type.

Verification
REQ-033 SHALL verify: reg_write_sig=1, reg_num=5, reg_data=32'h1234 -> next cycle trace_valid=1 and entry {rw=1, reg_num=5, reg_data=32'h1234, ms=ml=0}.
REQ-034 SHALL verify: reg_write_sig=1, reg_num=0, wr=rd=0 -> no push and level stays 0.
REQ-035 SHALL verify: rd=1, addr=9'h010, rd_data=32'hCAFE with reg_write_sig=1, reg_num=7 -> a single entry with rw=1, ml=1, mem_data=32'hCAFE.
REQ-036 SHALL verify: with trace_ready=0, 18 events at DEPTH=16 -> level=16, overflow=1, drop_count=2, and the first 16 events drain in order.
REQ-037 SHALL verify: when full, push and pop on the same cycle -> level stays 16 and drop_count is unchanged.
REQ-038 SHALL verify: reset=0 asserted while level=5 -> next cycle level=0, trace_valid=0, overflow=0.
